// File: rtl/my9262_pkg.sv
// my9262_pkg: shared latch-mode codes, feeder states and default chain geometry
package my9262_pkg;
    localparam int N_CHIPS_DEF = 32;
    localparam int N_CH_DEF    = 16;
    localparam logic [1:0] LAT_NONE   = 2'd0;
    localparam logic [1:0] LAT_DATA   = 2'd1;
    localparam logic [1:0] LAT_GLOBAL = 2'd2;
    localparam logic [1:0] LAT_CFG    = 2'd3;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_SEND,
        ST_CFG_WAIT,
        ST_GS_RD,
        ST_GS_SEND,
        ST_GS_WAIT,
        ST_DONE
    } feeder_state_e;
endpackage

// File: rtl/my9262_gs_ram.sv
// my9262_gs_ram: simple dual-port frame RAM, one write port, one registered read port
module my9262_gs_ram #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // write port plus one-cycle registered read; contents are never reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/my9262_gs_feeder.sv
// my9262_gs_feeder: double-buffered grayscale frame store feeding the MY9262 serializer word by word
module my9262_gs_feeder
    import my9262_pkg::*;
#(
    parameter int N_CHIPS = N_CHIPS_DEF,
    parameter int N_CH    = N_CH_DEF,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 4095,
    localparam int AW     = $clog2(N_CHIPS * N_CH)
) (
    input  logic              CLK_200M,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              swap_req,
    input  logic              cfg_req,
    input  logic [DATA_W-1:0] cfg_word,
    input  logic              frame_start,
    output logic [DATA_W-1:0] sd_data,
    output logic [1:0]        sd_lat_mode,
    output logic              sd_start,
    input  logic              sd_finish,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic              err_timeout
);
    localparam int CW = $clog2(N_CHIPS);
    localparam int HW = $clog2(N_CH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CHIP_MAX = CW'(N_CHIPS - 1);
    localparam logic [HW-1:0] CH_MAX   = HW'(N_CH - 1);

    feeder_state_e     state_q, state_d;
    logic              front_q, front_d;
    logic              swap_pend_q, swap_pend_d;
    logic              cfg_pend_q, cfg_pend_d;
    logic [CW-1:0]     chip_q, chip_d;
    logic [HW-1:0]     ch_q, ch_d;
    logic [TW-1:0]     wcnt_q, wcnt_d;
    logic [DATA_W-1:0] cfgw_q, cfgw_d;
    logic [DATA_W-1:0] sd_data_q, sd_data_d;
    logic [1:0]        lat_q, lat_d;
    logic              sd_start_q, sd_start_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_data;
    logic              accept, last_chip, last_ch, wait_st, cfg_now;

    // physical address is {bank, ch, chip}; host writes always land in the current back bank
    my9262_gs_ram #(.DEPTH(2 * N_CHIPS * N_CH), .DATA_W(DATA_W)) u_ram (
        .clk  (CLK_200M),
        .we   (wr_en),
        .waddr({~front_q, wr_addr}),
        .wdata(wr_data),
        .raddr({front_q, ch_q, chip_q}),
        .rdata(rd_data)
    );

    // next-state: frame sequencing, pending-request bookkeeping and finish timeout
    always_comb begin
        state_d      = state_q;
        front_d      = front_q;
        swap_pend_d  = swap_pend_q | swap_req;
        cfg_pend_d   = cfg_pend_q | cfg_req;
        chip_d       = chip_q;
        ch_d         = ch_q;
        wcnt_d       = wcnt_q;
        cfgw_d       = cfgw_q;
        sd_data_d    = sd_data_q;
        lat_d        = lat_q;
        sd_start_d   = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q | (frame_start & busy_q);
        err_d        = err_q;
        accept       = sd_finish & ~sd_start_q;
        last_chip    = chip_q == '0;
        last_ch      = ch_q == CH_MAX;
        wait_st      = state_q == ST_CFG_WAIT || state_q == ST_GS_WAIT;
        cfg_now      = cfg_pend_q | cfg_req;
        case (state_q)
            ST_IDLE: if (frame_start) begin
                front_d     = front_q ^ (swap_pend_q | swap_req);
                swap_pend_d = swap_pend_q & swap_req;
                cfg_pend_d  = cfg_pend_q & cfg_req;
                cfgw_d      = cfg_now ? cfg_word : cfgw_q;
                busy_d      = 1'b1;
                chip_d      = CHIP_MAX;
                ch_d        = '0;
                state_d     = cfg_now ? ST_CFG_SEND : ST_GS_RD;
            end
            ST_CFG_SEND: begin
                sd_data_d  = cfgw_q;
                lat_d      = last_chip ? LAT_CFG : LAT_NONE;
                sd_start_d = 1'b1;
                wcnt_d     = '0;
                state_d    = ST_CFG_WAIT;
            end
            ST_CFG_WAIT: begin
                wcnt_d  = accept ? wcnt_q : wcnt_q + 1'b1;
                chip_d  = !accept ? chip_q : last_chip ? CHIP_MAX : chip_q - 1'b1;
                state_d = !accept ? state_q : last_chip ? ST_GS_RD : ST_CFG_SEND;
            end
            ST_GS_RD: state_d = ST_GS_SEND;
            ST_GS_SEND: begin
                sd_data_d  = rd_data;
                lat_d      = !last_chip ? LAT_NONE : last_ch ? LAT_GLOBAL : LAT_DATA;
                sd_start_d = 1'b1;
                wcnt_d     = '0;
                state_d    = ST_GS_WAIT;
            end
            ST_GS_WAIT: begin
                wcnt_d  = accept ? wcnt_q : wcnt_q + 1'b1;
                chip_d  = !accept ? chip_q : !last_chip ? chip_q - 1'b1 : last_ch ? chip_q : CHIP_MAX;
                ch_d    = accept && last_chip && !last_ch ? ch_q + 1'b1 : ch_q;
                state_d = !accept ? state_q : (last_chip && last_ch) ? ST_DONE : ST_GS_RD;
            end
            ST_DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wait_st && !accept && wcnt_q == TW'(TIMEOUT - 1)) begin
            err_d      = 1'b1;
            busy_d     = 1'b0;
            cfg_pend_d = 1'b1;
            state_d    = ST_IDLE;
        end
    end

    // state register; reset forces config on the first frame
    always_ff @(posedge CLK_200M or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            front_q      <= 1'b0;
            swap_pend_q  <= 1'b0;
            cfg_pend_q   <= 1'b1;
            chip_q       <= '0;
            ch_q         <= '0;
            wcnt_q       <= '0;
            cfgw_q       <= '0;
            sd_data_q    <= '0;
            lat_q        <= LAT_NONE;
            sd_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            swap_pend_q  <= swap_pend_d;
            cfg_pend_q   <= cfg_pend_d;
            chip_q       <= chip_d;
            ch_q         <= ch_d;
            wcnt_q       <= wcnt_d;
            cfgw_q       <= cfgw_d;
            sd_data_q    <= sd_data_d;
            lat_q        <= lat_d;
            sd_start_q   <= sd_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            err_q        <= err_d;
        end
    end

    assign sd_data     = sd_data_q;
    assign sd_lat_mode = lat_q;
    assign sd_start    = sd_start_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign err_timeout = err_q;
endmodule

// File: doc/my9262_gs_feeder.md
Name: my9262_gs_feeder

Overview:
- Upstream stage of the MY9262 serializer. It holds a double-buffered grayscale frame for a daisy chain of MY9262 drivers.
- On each frame request it issues one 16-bit word at a time to the serializer, with a start/finish handshake and a latch-mode tag per word. An optional configuration word per chip is sent first.
- The host writes the back bank through a simple write port. Bank swap happens only at a frame boundary.

Parameters:
- N_CHIPS, 32, number of cascaded MY9262 devices.
- N_CH, 16, grayscale channels per device.
- DATA_W, 16, word width to the serializer.
- TIMEOUT, 4095, maximum cycles to wait for sd_finish before abort.

Ports:
- CLK_200M  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- wr_en  in  1  host write strobe (back bank).
- wr_addr  in  AW=clog2(N_CHIPS*N_CH)  {channel, chip} index, chip in the LSBs.
- wr_data  in  DATA_W  grayscale value.
- swap_req  in  1  pulse: make the back bank the front at the next frame start.
- cfg_req  in  1  pulse: send configuration before the next frame.
- cfg_word  in  DATA_W  configuration value, sampled at frame start.
- frame_start  in  1  pulse: begin sending the front bank.
- sd_data  out  DATA_W  word presented to the serializer.
- sd_lat_mode  out  2  0 none, 1 data latch, 2 global latch, 3 config latch.
- sd_start  out  1  one-cycle pulse; sd_data and sd_lat_mode are valid and held until sd_finish.
- sd_finish  in  1  one-cycle pulse from the serializer: word shifted and latched.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last word finishes.
- overrun  out  1  sticky; frame_start arrived while busy.
- err_timeout  out  1  sticky; sd_finish not seen within TIMEOUT cycles.

Behaviour:
- Reset values (RST high, asynchronous):
  - All outputs 0; front_bank=0; swap_pend=0; cfg_pend=1, so the first frame after reset always sends config; state IDLE.
  - RAM contents are not reset.
- Memory: 2*N_CHIPS*N_CH words, physical address {bank, wr_addr}.
  - Writes always target bank ~front_bank as it stands in that cycle.
  - A write in the same cycle as a swap goes to the pre-swap back bank, which becomes the new front.
  - Read latency is 1 cycle (registered).
- swap_req and cfg_req set pending flags. The flags are cleared when consumed at frame start. A request arriving in the same cycle as consumption stays pending for the following frame.
- FSM:
  - IDLE: on frame_start, apply the swap if swap_pend, capture cfg_word if cfg_pend, and set busy. Go to CFG_SEND if cfg_pend, else GS_RD. chip=N_CHIPS-1, ch=0.
  - CFG_SEND: sd_data=cfg_word; sd_lat_mode=3 only for chip 0, else 0; pulse sd_start; go to CFG_WAIT.
  - CFG_WAIT: on sd_finish, if chip==0 go to GS_RD (chip reloaded to N_CHIPS-1); else chip-1 and go to CFG_SEND.
  - GS_RD: issue the RAM read of {front_bank, ch, chip}; go to GS_SEND next cycle.
  - GS_SEND: register the RAM output to sd_data and pulse sd_start. sd_lat_mode depends on chip and ch:
    - chip!=0: 0.
    - chip==0 and ch!=N_CH-1: 1.
    - chip==0 and ch==N_CH-1: 2.
  - GS_WAIT: on sd_finish:
    - chip!=0: chip-1, go to GS_RD.
    - chip==0 and ch!=N_CH-1: ch+1, chip=N_CHIPS-1, go to GS_RD.
    - chip==0 and ch==N_CH-1: go to DONE.
  - DONE: pulse frame_done, clear busy, go to IDLE.
- Word order: farthest chip first (N_CHIPS-1 down to 0), channel 0 to N_CH-1. Each frame is N_CHIPS*N_CH grayscale words, plus N_CHIPS config words when config is sent.
- Handshake rules:
  - Exactly one sd_start per word.
  - sd_data and sd_lat_mode are stable from sd_start until sd_finish.
  - sd_finish outside a WAIT state is ignored.
  - sd_finish in the same cycle as sd_start is not accepted; it is counted only from the cycle after sd_start.
- Timeout:
  - The wait counter clears at each sd_start and increments in WAIT states.
  - Reaching TIMEOUT sets err_timeout and returns to IDLE with busy=0. No frame_done is issued. cfg_pend is set so the next frame resends config.
- frame_start while busy: ignored, overrun set. Sticky flags clear only on reset.
- Reset mid-frame: immediate return to IDLE, sd_start low, all counters cleared.
- Counters: chip width clog2(N_CHIPS), ch width clog2(N_CH); no wrap, since bounds are checked explicitly.

Decomposition:
- Package my9262_pkg holds:
  - LAT_NONE/LAT_DATA/LAT_GLOBAL/LAT_CFG constants (2-bit);
  - the feeder state enum;
  - default N_CHIPS/N_CH.
- One sub-module, my9262_gs_ram: simple dual-port RAM with one write port and one registered read port; parameters DEPTH and DATA_W.

Test Plan:
1. N_CHIPS=2, N_CH=2; reset, cfg_word=16'h0EA0, frame_start; serializer model answers 8 cycles after each start. Required response:
   - 2 config words, lat modes 0 then 3;
   - then 4 gs words in order (chip1,ch0), (chip0,ch0), (chip1,ch1), (chip0,ch1), lat 0,1,0,2;
   - frame_done once, busy low after.
2. Write back-bank values 16'h00FF..16'h00FF+3, swap_req, frame_start → new values sent; a second frame without cfg_req sends no config words.
3. frame_start asserted during busy → overrun=1; the current frame completes normally with the same 4 gs words.
4. Serializer model withholds sd_finish with TIMEOUT=20 → err_timeout=1 within 21 cycles, busy=0, no frame_done; the next frame starts with config words.
5. Assert RST mid-GS_WAIT → sd_start=0, busy=0 immediately; the next frame_start begins with config (cfg_pend=1).
6. swap_req and frame_start in the same cycle, plus a write in that cycle → the swap is applied to this frame, and the written word appears in the data sent.
